// File: rtl/vga_pkg.sv
// Shared types and constants for the bouncing-circle VGA generator.
// Colour format, object palette and small elaboration helpers.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t COLOUR_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};

    // Object i is drawn in PALETTE[i]; index 0 has the highest priority.
    localparam rgb444_t PALETTE [8] = '{
        '{r: 4'h0, g: 4'hF, b: 4'h0},
        '{r: 4'hF, g: 4'h0, b: 4'h0},
        '{r: 4'h0, g: 4'h0, b: 4'hF},
        '{r: 4'hF, g: 4'hF, b: 4'h0},
        '{r: 4'h0, g: 4'hF, b: 4'hF},
        '{r: 4'hF, g: 4'h0, b: 4'hF},
        '{r: 4'hF, g: 4'hF, b: 4'hF},
        '{r: 4'hF, g: 4'h8, b: 4'h0}
    };

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters with sync, active and frame decode.
// All decoded flags are combinational from the counter registers.
module vga_timing #(
    parameter int HWIDTH  = 640,
    parameter int HFPORCH = 16,
    parameter int HSYNC   = 96,
    parameter int HBPORCH = 48,
    parameter int VWIDTH  = 480,
    parameter int VFPORCH = 10,
    parameter int VSYNC   = 2,
    parameter int VBPORCH = 33,
    parameter int HCW     = $clog2(HWIDTH + HFPORCH + HSYNC + HBPORCH),
    parameter int VCW     = $clog2(VWIDTH + VFPORCH + VSYNC + VBPORCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [HCW-1:0] hcnt_o,
    output logic [VCW-1:0] vcnt_o,
    output logic           hs_act_o,
    output logic           vs_act_o,
    output logic           active_o,
    output logic           frame_start_o
);

    localparam int HTOTAL = HWIDTH + HFPORCH + HSYNC + HBPORCH;
    localparam int VTOTAL = VWIDTH + VFPORCH + VSYNC + VBPORCH;

    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic           h_wrap, v_wrap;
    logic [HCW:0]   h_x;
    logic [VCW:0]   v_x;

    assign h_wrap = (hcnt_q == HCW'(HTOTAL - 1));
    assign v_wrap = (vcnt_q == VCW'(VTOTAL - 1));

    // Next counter values: h wraps every line, v steps on each h wrap.
    always_comb begin
        hcnt_d = h_wrap ? '0 : hcnt_q + HCW'(1);
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = v_wrap ? '0 : vcnt_q + VCW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // One extra bit so sync end points equal to the total still compare.
    assign h_x = {1'b0, hcnt_q};
    assign v_x = {1'b0, vcnt_q};

    assign hs_act_o = (h_x >= (HCW+1)'(HWIDTH + HFPORCH)) &&
                      (h_x <  (HCW+1)'(HWIDTH + HFPORCH + HSYNC));
    assign vs_act_o = (v_x >= (VCW+1)'(VWIDTH + VFPORCH)) &&
                      (v_x <  (VCW+1)'(VWIDTH + VFPORCH + VSYNC));
    assign active_o = (h_x < (HCW+1)'(HWIDTH)) &&
                      (v_x < (VCW+1)'(VWIDTH));

    assign frame_start_o = (hcnt_q == '0) && (vcnt_q == VCW'(VWIDTH));

    assign hcnt_o = hcnt_q;
    assign vcnt_o = vcnt_q;

endmodule

// File: rtl/vga_bounce_gen.sv
// VGA timing plus NOBJ bouncing filled circles, each in its own colour.
// Two-stage pixel pipeline: S1 centre offsets, S2 radius test; syncs delayed to match.
module vga_bounce_gen
    import vga_pkg::*;
#(
    parameter int HWIDTH  = 640,
    parameter int HFPORCH = 16,
    parameter int HSYNC   = 96,
    parameter int HBPORCH = 48,
    parameter int VWIDTH  = 480,
    parameter int VFPORCH = 10,
    parameter int VSYNC   = 2,
    parameter int VBPORCH = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int NOBJ    = 2,
    parameter int RADIUS  = 30,
    parameter int SPEED   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       frame_start,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS
);

    localparam int HTOTAL = HWIDTH + HFPORCH + HSYNC + HBPORCH;
    localparam int VTOTAL = VWIDTH + VFPORCH + VSYNC + VBPORCH;
    localparam int HCW    = $clog2(HTOTAL);
    localparam int VCW    = $clog2(VTOTAL);
    localparam int SQW    = 2 * (imax(HCW, VCW) + 1) + 1;
    localparam int XHI    = HWIDTH - 1 - RADIUS;
    localparam int YHI    = VWIDTH - 1 - RADIUS;
    localparam int LOLIM  = RADIUS + SPEED;

    if (NOBJ < 1 || NOBJ > 8) begin : g_chk_nobj
        $error("vga_bounce_gen: NOBJ must be 1..8");
    end
    if (RADIUS * (NOBJ + 1) > imin(HWIDTH, VWIDTH) - 1) begin : g_chk_rad
        $error("vga_bounce_gen: circles do not fit the visible area");
    end
    if (SPEED < 1 || SPEED > RADIUS) begin : g_chk_speed
        $error("vga_bounce_gen: SPEED must be 1..RADIUS");
    end

    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
    logic           hs_act, vs_act, active;

    vga_timing #(
        .HWIDTH  (HWIDTH),
        .HFPORCH (HFPORCH),
        .HSYNC   (HSYNC),
        .HBPORCH (HBPORCH),
        .VWIDTH  (VWIDTH),
        .VFPORCH (VFPORCH),
        .VSYNC   (VSYNC),
        .VBPORCH (VBPORCH),
        .HCW     (HCW),
        .VCW     (VCW)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .hcnt_o        (hcnt),
        .vcnt_o        (vcnt),
        .hs_act_o      (hs_act),
        .vs_act_o      (vs_act),
        .active_o      (active),
        .frame_start_o (frame_start)
    );

    logic            move;
    logic [NOBJ-1:0] hit_vec;

    assign move = frame_start & en;

    for (genvar i = 0; i < NOBJ; i++) begin : g_obj
        logic [HCW-1:0]     cx_q, cx_d;
        logic [VCW-1:0]     cy_q, cy_d;
        logic               dirx_q, dirx_d;
        logic               diry_q, diry_d;
        logic [HCW:0]       cx_up;
        logic [VCW:0]       cy_up;
        logic signed [HCW:0] dx_q;
        logic signed [VCW:0] dy_q;
        logic [HCW:0]       dxa;
        logic [VCW:0]       dya;
        logic [SQW-1:0]     d2;
        logic               hit_q;

        assign cx_up = {1'b0, cx_q} + (HCW+1)'(SPEED);
        assign cy_up = {1'b0, cy_q} + (VCW+1)'(SPEED);

        // Bounce step per axis: clamp to the wall and reverse on contact.
        always_comb begin
            cx_d   = cx_q;
            dirx_d = dirx_q;
            cy_d   = cy_q;
            diry_d = diry_q;
            if (!dirx_q) begin
                if (cx_up >= (HCW+1)'(XHI)) begin
                    cx_d   = HCW'(XHI);
                    dirx_d = 1'b1;
                end else begin
                    cx_d = cx_up[HCW-1:0];
                end
            end else begin
                if ({1'b0, cx_q} <= (HCW+1)'(LOLIM)) begin
                    cx_d   = HCW'(RADIUS);
                    dirx_d = 1'b0;
                end else begin
                    cx_d = cx_q - HCW'(SPEED);
                end
            end
            if (!diry_q) begin
                if (cy_up >= (VCW+1)'(YHI)) begin
                    cy_d   = VCW'(YHI);
                    diry_d = 1'b1;
                end else begin
                    cy_d = cy_up[VCW-1:0];
                end
            end else begin
                if ({1'b0, cy_q} <= (VCW+1)'(LOLIM)) begin
                    cy_d   = VCW'(RADIUS);
                    diry_d = 1'b0;
                end else begin
                    cy_d = cy_q - VCW'(SPEED);
                end
            end
        end

        // Centre and direction state, updated once per frame when enabled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cx_q   <= HCW'(RADIUS * (i + 1));
                cy_q   <= VCW'(RADIUS * (i + 1));
                dirx_q <= ((i % 2) == 1);
                diry_q <= 1'b0;
            end else if (move) begin
                cx_q   <= cx_d;
                cy_q   <= cy_d;
                dirx_q <= dirx_d;
                diry_q <= diry_d;
            end
        end

        assign dxa = dx_q[HCW] ? $unsigned(-dx_q) : $unsigned(dx_q);
        assign dya = dy_q[VCW] ? $unsigned(-dy_q) : $unsigned(dy_q);
        assign d2  = SQW'(dxa) * SQW'(dxa) + SQW'(dya) * SQW'(dya);

        // S1 offsets from the centre, S2 inside-circle flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dx_q  <= '0;
                dy_q  <= '0;
                hit_q <= 1'b0;
            end else begin
                dx_q  <= $signed({1'b0, hcnt}) - $signed({1'b0, cx_q});
                dy_q  <= $signed({1'b0, vcnt}) - $signed({1'b0, cy_q});
                hit_q <= (d2 <= SQW'(RADIUS * RADIUS));
            end
        end

        assign hit_vec[i] = hit_q;
    end

    logic    hs_s1_q, vs_s1_q, act_s1_q;
    logic    hs_s2_q, vs_s2_q, act_s2_q;
    rgb444_t colour;

    // Delay sync and active by two clocks to line up with hit flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            act_s1_q <= 1'b0;
            hs_s2_q  <= ~HS_POL;
            vs_s2_q  <= ~VS_POL;
            act_s2_q <= 1'b0;
        end else begin
            hs_s1_q  <= hs_act;
            vs_s1_q  <= vs_act;
            act_s1_q <= active;
            hs_s2_q  <= hs_s1_q ? HS_POL : ~HS_POL;
            vs_s2_q  <= vs_s1_q ? VS_POL : ~VS_POL;
            act_s2_q <= act_s1_q;
        end
    end

    // Lowest-index hit wins; black outside the visible area.
    always_comb begin
        colour = COLOUR_BLACK;
        if (act_s2_q) begin
            for (int k = NOBJ - 1; k >= 0; k--) begin
                if (hit_vec[k]) begin
                    colour = PALETTE[k[2:0]];
                end
            end
        end
    end

    assign VGA_R  = colour.r;
    assign VGA_G  = colour.g;
    assign VGA_B  = colour.b;
    assign VGA_HS = hs_s2_q;
    assign VGA_VS = vs_s2_q;

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Scoreboard bench for vga_bounce_gen on a small 72x51 raster.
// Expected pins are queued per counter cycle and compared two clocks later.
module tb_vga_bounce_gen;

    localparam int HT   = 72;
    localparam int VT   = 51;
    localparam int FRM  = HT * VT;
    localparam int NSP  = 17;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       frame_start;
    logic [3:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS;

    always #5 clk = ~clk;

    vga_bounce_gen #(
        .HWIDTH  (64),
        .HFPORCH (2),
        .HSYNC   (4),
        .HBPORCH (2),
        .VWIDTH  (48),
        .VFPORCH (1),
        .VSYNC   (1),
        .VBPORCH (1),
        .HS_POL  (1'b0),
        .VS_POL  (1'b0),
        .NOBJ    (2),
        .RADIUS  (4),
        .SPEED   (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .frame_start (frame_start),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS)
    );

    typedef struct {
        int          f;
        int          h;
        int          v;
        logic [13:0] e;
    } ent_t;

    ent_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   mh, mv, mf, cyc;
    int   cx [2];
    int   cy [2];
    bit   dxr [2];
    bit   dyr [2];
    int   last_fs, hs_run, vs_run;
    bit   hs_prev, hs_seen;

    // {frame, h, v, rgb}
    int spot [NSP][4] = '{
        '{0, 4, 4, 'h0F0}, '{0, 8, 4, 'h0F0}, '{0, 9, 4, 'h000},
        '{0, 64, 4, 'h000}, '{0, 6, 6, 'h0F0}, '{0, 11, 8, 'hF00},
        '{2, 14, 10, 'h0F0}, '{2, 15, 10, 'h000},
        '{5, 15, 10, 'h000}, '{6, 15, 10, 'h0F0},
        '{21, 62, 28, 'h0F0}, '{21, 63, 28, 'h000},
        '{22, 63, 25, 'h0F0}, '{22, 55, 25, 'h0F0},
        '{23, 60, 22, 'h0F0}, '{23, 61, 22, 'h000}, '{23, 52, 22, 'h0F0}
    };

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (h=%0d v=%0d f=%0d)",
                     tag, got, want, mh, mv, mf);
        end
    endtask

    function automatic logic [11:0] pix(input int h, input int v);
        if (h >= 64 || v >= 48) return 12'h000;
        for (int i = 0; i < 2; i++) begin
            if ((h - cx[i]) * (h - cx[i]) + (v - cy[i]) * (v - cy[i]) <= 16)
                return (i == 0) ? 12'h0F0 : 12'hF00;
        end
        return 12'h000;
    endfunction

    task automatic bounce(inout int c, inout bit d, input int hi);
        if (!d) begin
            if (c + 3 >= hi) begin
                c = hi;
                d = 1'b1;
            end else begin
                c = c + 3;
            end
        end else begin
            if (c <= 7) begin
                c = 4;
                d = 1'b0;
            end else begin
                c = c - 3;
            end
        end
    endtask

    task automatic model_init();
        ent_t r;
        mh = 0; mv = 0; mf = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            cx[i]  = 4 * (i + 1);
            cy[i]  = 4 * (i + 1);
            dxr[i] = (i % 2 == 1);
            dyr[i] = 1'b0;
        end
        sbq.delete();
        r.f = -1; r.h = -1; r.v = -1;
        r.e = {1'b1, 1'b1, 12'h000};
        sbq.push_back(r);
        sbq.push_back(r);
        last_fs = -1; hs_run = 0; vs_run = 0;
        hs_prev = 1'b1; hs_seen = 1'b0;
    endtask

    task automatic step();
        ent_t        e, o;
        bit          fs_now;
        logic [14:0] got;
        #1;
        fs_now = (mh == 0 && mv == 48);
        e.f = mf; e.h = mh; e.v = mv;
        e.e = {!(mh >= 66 && mh < 70), !(mv == 49), pix(mh, mv)};
        sbq.push_back(e);
        o = sbq.pop_front();
        got = {frame_start, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};
        chk("pins", got, {fs_now, o.e});
        for (int k = 0; k < NSP; k++) begin
            if (o.f == spot[k][0] && o.h == spot[k][1] && o.v == spot[k][2])
                chk("spot", {VGA_R, VGA_G, VGA_B}, spot[k][3]);
        end
        if (frame_start) begin
            if (last_fs >= 0) chk("fs_period", cyc - last_fs, FRM);
            last_fs = cyc;
        end
        if (!VGA_HS) hs_run++;
        else if (hs_run > 0) begin
            chk("hs_width", hs_run, 4);
            hs_run = 0;
        end
        if (!VGA_VS) vs_run++;
        else if (vs_run > 0) begin
            chk("vs_width", vs_run, HT);
            vs_run = 0;
        end
        if (!hs_seen && hs_prev && !VGA_HS) begin
            hs_seen = 1'b1;
            chk("hs_first", cyc, 68);
        end
        hs_prev = VGA_HS;
        if (fs_now && en) begin
            for (int i = 0; i < 2; i++) begin
                bounce(cx[i], dxr[i], 59);
                bounce(cy[i], dyr[i], 43);
            end
        end
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) begin
                mv = 0;
                mf++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pins", {frame_start, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B},
            15'h3000);
        rst_n = 1'b1;
        model_init();
        for (int n = 0; n < 10000 && !(mh == 10 && mv == 6); n++) step();
        chk("pre_rst_rgb", {VGA_R, VGA_G, VGA_B}, 12'hF00);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {frame_start, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B},
            15'h3000);
        @(negedge clk);
        chk("rst_hold", {frame_start, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B},
            15'h3000);
        @(negedge clk);
        rst_n = 1'b1;
        model_init();
        for (int n = 0; n < 95000 && !(mf == 23 && mv == 26); n++) begin
            en = !(mf >= 2 && mf <= 4);
            step();
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
